// File: rtl/txpippm_pkg.sv
// Shared types and constants for the TX phase-interpolator PPM stepper.
package txpippm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Stepsize word layout: direction in the MSB, magnitude below it
  localparam int unsigned STEPSIZE_WIDTH   = 5;
  localparam int unsigned STEPSIZE_DIR_BIT = 4;
  localparam int unsigned STEPSIZE_MAG_MSB = 3;
  localparam int unsigned STEPSIZE_MAG_LSB = 0;

  typedef struct packed {
    logic                                   dir;
    logic [STEPSIZE_MAG_MSB:STEPSIZE_MAG_LSB] mag;
  } stepsize_t;

  // Fixed per-channel PI control levels while the stepper owns the PI
  localparam logic PPM_OVRDEN_VAL = 1'b0;
  localparam logic PPM_SEL_VAL    = 1'b1;
  localparam logic PPM_PD_VAL     = 1'b0;

endpackage

// File: rtl/txpippm_gap_timer.sv
// Loadable down-counter with a minimum-value clamp. expired flags the last
// counted cycle, near_expired the cycle before it.
module txpippm_gap_timer #(
  parameter int unsigned GAP_WIDTH = 8,
  parameter int unsigned MIN_GAP   = 4
) (
  input  logic                 gtwiz_userclk_tx_usrclk_in,
  input  logic                 gtwiz_reset_all_n_in,
  input  logic                 load,
  input  logic [GAP_WIDTH-1:0] value,
  output logic                 expired,
  output logic                 near_expired
);

  localparam logic [GAP_WIDTH-1:0] MIN_VAL = GAP_WIDTH'(MIN_GAP);
  localparam logic [GAP_WIDTH-1:0] ONE     = GAP_WIDTH'(1);
  localparam logic [GAP_WIDTH-1:0] TWO     = GAP_WIDTH'(2);
  localparam logic [GAP_WIDTH-1:0] THREE   = GAP_WIDTH'(3);

  logic [GAP_WIDTH-1:0] count_q;
  logic [GAP_WIDTH-1:0] load_val_c;

  // Clamp the requested gap up to the minimum
  always_comb begin
    load_val_c = (value < MIN_VAL) ? MIN_VAL : value;
  end

  // Count register with flags registered against the next count value
  always_ff @(posedge gtwiz_userclk_tx_usrclk_in or negedge gtwiz_reset_all_n_in) begin
    if (!gtwiz_reset_all_n_in) begin
      count_q      <= '0;
      expired      <= 1'b0;
      near_expired <= 1'b0;
    end else if (load) begin
      count_q      <= load_val_c;
      expired      <= (load_val_c == ONE);
      near_expired <= (load_val_c == TWO);
    end else if (count_q != '0) begin
      count_q      <= count_q - ONE;
      expired      <= (count_q == TWO);
      near_expired <= (count_q == THREE);
    end
  end

endmodule

// File: rtl/txpippm_stepper.sv
// Counted, rate-limited, abortable TXPIPPMEN strobe generator for a group of
// GT transmit channels. The terminal gap's last idle cycle is spent in IDLE,
// so a follow-on command's first strobe keeps the full strobe spacing.
module txpippm_stepper
  import txpippm_pkg::*;
#(
  parameter int unsigned CHANNEL_COUNT = 10,
  parameter int unsigned STEP_WIDTH    = 16,
  parameter int unsigned GAP_WIDTH     = 8,
  parameter int unsigned MIN_GAP       = 4
) (
  input  logic                                    gtwiz_userclk_tx_usrclk_in,
  input  logic                                    gtwiz_reset_all_n_in,
  input  logic                                    cmd_valid_in,
  output logic                                    cmd_ready_out,
  input  logic [CHANNEL_COUNT-1:0]                cmd_mask_in,
  input  logic [STEP_WIDTH-1:0]                   cmd_steps_in,
  input  logic [STEPSIZE_WIDTH-1:0]               cmd_stepsize_in,
  input  logic [GAP_WIDTH-1:0]                    cmd_gap_in,
  input  logic                                    abort_in,
  output logic                                    busy_out,
  output logic                                    done_out,
  output logic                                    aborted_out,
  output logic [STEP_WIDTH-1:0]                   steps_done_out,
  output logic [CHANNEL_COUNT-1:0]                txpippmen_out,
  output logic [CHANNEL_COUNT-1:0]                txpippmovrden_out,
  output logic [CHANNEL_COUNT-1:0]                txpippmsel_out,
  output logic [CHANNEL_COUNT-1:0]                txpippmpd_out,
  output logic [CHANNEL_COUNT*STEPSIZE_WIDTH-1:0] txpippmstepsize_out
);

  state_e                   state_q;
  logic [CHANNEL_COUNT-1:0] mask_q;
  logic [CHANNEL_COUNT-1:0] txpippmen_q;
  logic [STEP_WIDTH-1:0]    steps_q;
  logic [STEP_WIDTH-1:0]    steps_done_q;
  logic [GAP_WIDTH-1:0]     gap_q;
  stepsize_t                stepsize_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     aborted_q;
  logic                     abort_pend_q;

  logic                     gap_expired;
  logic                     gap_near_expired;
  logic [STEP_WIDTH-1:0]    issued_c;
  logic                     final_c;
  logic                     term_c;
  logic                     gap_is_one_c;

  // Gap timer, reloaded on every strobe cycle
  txpippm_gap_timer #(
    .GAP_WIDTH (GAP_WIDTH),
    .MIN_GAP   (MIN_GAP)
  ) u_gap_timer (
    .gtwiz_userclk_tx_usrclk_in (gtwiz_userclk_tx_usrclk_in),
    .gtwiz_reset_all_n_in       (gtwiz_reset_all_n_in),
    .load                       (state_q == ST_PULSE),
    .value                      (gap_q),
    .expired                    (gap_expired),
    .near_expired               (gap_near_expired)
  );

  // Termination decision: count reached, or abort pending/arriving now
  always_comb begin
    issued_c     = (state_q == ST_PULSE) ? steps_done_q + STEP_WIDTH'(1) : steps_done_q;
    final_c      = (steps_q != '0) && (issued_c == steps_q);
    term_c       = final_c || abort_pend_q || abort_in;
    gap_is_one_c = (MIN_GAP <= 1) && (gap_q <= GAP_WIDTH'(1));
  end

  // Burst sequencer with registered outputs
  always_ff @(posedge gtwiz_userclk_tx_usrclk_in or negedge gtwiz_reset_all_n_in) begin
    if (!gtwiz_reset_all_n_in) begin
      state_q      <= ST_IDLE;
      mask_q       <= '0;
      txpippmen_q  <= '0;
      steps_q      <= '0;
      steps_done_q <= '0;
      gap_q        <= '0;
      stepsize_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      txpippmen_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid_in) begin
            mask_q         <= cmd_mask_in;
            steps_q        <= cmd_steps_in;
            gap_q          <= cmd_gap_in;
            stepsize_q.dir <= cmd_stepsize_in[STEPSIZE_DIR_BIT];
            stepsize_q.mag <= cmd_stepsize_in[STEPSIZE_MAG_MSB:STEPSIZE_MAG_LSB];
            steps_done_q   <= '0;
            aborted_q      <= 1'b0;
            abort_pend_q   <= 1'b0;
            txpippmen_q    <= cmd_mask_in;
            busy_q         <= 1'b1;
            state_q        <= ST_PULSE;
          end
        end
        ST_PULSE: begin
          steps_done_q <= issued_c;
          if (abort_in) abort_pend_q <= 1'b1;
          if (gap_is_one_c && term_c) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            aborted_q <= !final_c;
          end else begin
            state_q <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (abort_in) abort_pend_q <= 1'b1;
          if (gap_near_expired && term_c) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            aborted_q <= !final_c;
          end else if (gap_expired) begin
            txpippmen_q <= mask_q;
            state_q     <= ST_PULSE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready_out       = (state_q == ST_IDLE);
  assign busy_out            = busy_q;
  assign done_out            = done_q;
  assign aborted_out         = aborted_q;
  assign steps_done_out      = steps_done_q;
  assign txpippmen_out       = txpippmen_q;
  assign txpippmovrden_out   = {CHANNEL_COUNT{PPM_OVRDEN_VAL}};
  assign txpippmsel_out      = {CHANNEL_COUNT{PPM_SEL_VAL}};
  assign txpippmpd_out       = {CHANNEL_COUNT{PPM_PD_VAL}};
  assign txpippmstepsize_out = {CHANNEL_COUNT{stepsize_q}};

endmodule

// File: tb/tb_txpippm_stepper.sv
// Scoreboard bench for txpippm_stepper: each command's expected strobe and
// done events are planned from the timing rules and checked by a monitor.
module tb_txpippm_stepper;

  localparam int CH = 10;
  localparam int SW = 16;
  localparam int GW = 8;
  localparam int MG = 4;

  typedef struct {
    int         cyc;
    bit         is_done;
    logic [9:0] mask;
    logic [15:0] steps;
    bit         aborted;
    logic [4:0] ss;
  } ev_t;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [CH-1:0] cmd_mask;
  logic [SW-1:0] cmd_steps;
  logic [4:0]    cmd_stepsize;
  logic [GW-1:0] cmd_gap;
  logic          abort;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [SW-1:0] steps_done;
  logic [CH-1:0] en;
  logic [CH-1:0] ovrden;
  logic [CH-1:0] sel;
  logic [CH-1:0] pd;
  logic [CH*5-1:0] stepsize_out;

  int   cyc;
  int   checks;
  int   errors;
  int   free_cyc;
  ev_t  exp_q[$];

  txpippm_stepper #(
    .CHANNEL_COUNT (CH),
    .STEP_WIDTH    (SW),
    .GAP_WIDTH     (GW),
    .MIN_GAP       (MG)
  ) dut (
    .gtwiz_userclk_tx_usrclk_in (clk),
    .gtwiz_reset_all_n_in       (rst_n),
    .cmd_valid_in               (cmd_valid),
    .cmd_ready_out              (cmd_ready),
    .cmd_mask_in                (cmd_mask),
    .cmd_steps_in               (cmd_steps),
    .cmd_stepsize_in            (cmd_stepsize),
    .cmd_gap_in                 (cmd_gap),
    .abort_in                   (abort),
    .busy_out                   (busy),
    .done_out                   (done),
    .aborted_out                (aborted),
    .steps_done_out             (steps_done),
    .txpippmen_out              (en),
    .txpippmovrden_out          (ovrden),
    .txpippmsel_out             (sel),
    .txpippmpd_out              (pd),
    .txpippmstepsize_out        (stepsize_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Plan a burst accepted in cycle a: strobe i lands at a+1+(i-1)(1+G); the
  // run stops at strobe N, or at the first strobe whose stop-decision cycle
  // (G-1 cycles after it) is not before the abort; done comes G cycles later.
  task automatic plan(input int a, input logic [9:0] m, input int n, input logic [4:0] ss,
                      input int g, input bit hab, input int t, input int cut,
                      output int done_c);
    int  gg;
    int  i;
    int  s;
    bit  stop;
    bit  ab;
    ev_t e;
    gg = (g < MG) ? MG : g;
    i = 0; s = a; stop = 0; ab = 0; done_c = -1;
    while (!stop && i < 5000) begin
      i++;
      s = a + 1 + (i - 1) * (1 + gg);
      if (m != 0) begin
        e = '{cyc: s, is_done: 0, mask: m, steps: 16'(i - 1), aborted: 0, ss: ss};
        exp_q.push_back(e);
      end
      if (cut != 0 && i == cut) return;
      if (n != 0 && i == n) stop = 1;
      else if (hab && (s + gg - 1) >= t) begin stop = 1; ab = 1; end
    end
    e = '{cyc: s + gg, is_done: 1, mask: '0, steps: 16'(i), aborted: ab, ss: ss};
    exp_q.push_back(e);
    done_c = s + gg;
  endtask

  // Issue one command (valid held until accepted) plus an optional abort pulse
  task automatic issue(input logic [9:0] m, input int n, input logic [4:0] ss, input int g,
                       input bit hab, input int off);
    int a;
    int d;
    a = (cyc > free_cyc) ? cyc : free_cyc;
    plan(a, m, n, ss, g, hab, a + off, 0, d);
    free_cyc     = d;
    cmd_valid    = 1'b1;
    cmd_mask     = m;
    cmd_steps    = 16'(n);
    cmd_stepsize = ss;
    cmd_gap      = 8'(g);
    wait_until(a);
    chk("ready_at_accept", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid    = 1'b0;
    cmd_mask     = 10'($urandom);
    cmd_steps    = 16'($urandom);
    cmd_stepsize = 5'($urandom);
    cmd_gap      = 8'($urandom);
    if (hab) begin
      wait_until(a + off);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
  endtask

  // Pops the next planned event whenever the DUT shows a strobe or done
  task automatic monitor();
    ev_t e;
    bit  ok;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        checks++; errors++;
        $display("FAIL missing_event cycle %0d: planned done=%0b at cycle %0d not seen", cyc, e.is_done, e.cyc);
      end
      if (en != '0 || done) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cycle %0d: en=%h done=%b, none planned", cyc, en, done);
        end else begin
          e = exp_q.pop_front();
          if (e.is_done)
            ok = done && en == '0 && cyc == e.cyc && steps_done == e.steps &&
                 aborted == e.aborted && !busy && cmd_ready;
          else
            ok = !done && en == e.mask && cyc == e.cyc && steps_done == e.steps &&
                 stepsize_out == {CH{e.ss}} && busy;
          if (!ok) begin
            errors++;
            $display("FAIL event cycle %0d: got en=%h done=%b busy=%b rdy=%b sd=%0d ab=%b ss=%h; expected cycle %0d en=%h done=%b sd=%0d ab=%b ss=%h",
                     cyc, en, done, busy, cmd_ready, steps_done, aborted, stepsize_out[4:0],
                     e.cyc, e.mask, e.is_done, e.steps, e.aborted, e.ss);
          end
        end
      end
    end
  endtask

  initial begin
    int d;
    int a;
    int n;
    int g;
    int off;
    bit hab;
    cyc = 0; checks = 0; errors = 0; free_cyc = 0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_mask = '0; cmd_steps = '0;
    cmd_stepsize = '0; cmd_gap = '0; abort = 1'b0;
    fork monitor(); join_none

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_aborted", 64'(aborted), 64'd0);
    chk("rst_steps_done", 64'(steps_done), 64'd0);
    chk("rst_en", 64'(en), 64'd0);
    chk("rst_stepsize", 64'(stepsize_out), 64'd0);
    chk("const_ovrden", 64'(ovrden), 64'd0);
    chk("const_sel", 64'(sel), 64'h3FF);
    chk("const_pd", 64'(pd), 64'd0);
    rst_n = 1'b1;
    free_cyc = cyc;
    repeat (2) @(negedge clk);

    // Basic three-strobe burst
    issue(10'h005, 3, 5'h13, 6, 0, 0);
    // Gap below minimum is clamped
    issue(10'h2A1, 2, 5'h04, 1, 0, 0);
    // Continuous run aborted in the 10th strobe cycle
    issue(10'h0F0, 0, 5'h1F, 4, 1, 1 + 9 * (1 + MG));
    wait_until(free_cyc + 1);
    chk("aborted_held", 64'(aborted), 64'd1);
    chk("steps_done_held", 64'(steps_done), 64'd10);
    chk("idle_busy", 64'(busy), 64'd0);
    // Abort in the final stop-decision cycle: normal end
    issue(10'h3FF, 3, 5'h08, 5, 1, 1 + 2 * 6 + 4);
    // Abort in the second strobe's decision cycle: aborted after two
    issue(10'h111, 3, 5'h18, 5, 1, 1 + 6 + 4);
    // Abort while idle is ignored
    wait_until(free_cyc + 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_busy", 64'(busy), 64'd0);
    issue(10'h042, 2, 5'h01, 4, 0, 0);
    // Back-to-back: second command waits for the done cycle
    issue(10'h00F, 2, 5'h0C, 5, 0, 0);
    issue(10'h3C0, 2, 5'h1C, 4, 0, 0);
    // All-zero mask still sequences
    issue(10'h000, 2, 5'h07, 4, 0, 0);

    // Reset during the second strobe
    a = (cyc > free_cyc) ? cyc : free_cyc;
    plan(a, 10'h3FF, 3, 5'h0A, 6, 0, 0, 2, d);
    cmd_valid = 1'b1; cmd_mask = 10'h3FF; cmd_steps = 16'd3; cmd_stepsize = 5'h0A; cmd_gap = 8'd6;
    wait_until(a);
    chk("ready_at_accept", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_until(a + 1 + 7);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_en", 64'(en), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_steps_done", 64'(steps_done), 64'd0);
    chk("rst_mid_stepsize", 64'(stepsize_out), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    free_cyc = cyc;
    @(negedge clk);
    chk("post_rst_ready", 64'(cmd_ready), 64'd1);
    chk("post_rst_steps_done", 64'(steps_done), 64'd0);
    chk("post_rst_en", 64'(en), 64'd0);

    // Randomized commands, sometimes back-to-back
    for (int k = 0; k < 14; k++) begin
      n = $urandom_range(0, 5);
      g = $urandom_range(0, 12);
      if (n == 0) begin
        hab = 1;
        off = $urandom_range(1, 40);
      end else begin
        hab = ($urandom_range(0, 2) == 0);
        off = $urandom_range(1, n * (1 + ((g < MG) ? MG : g)) - 1);
      end
      issue(10'($urandom), n, 5'($urandom), g, hab, off);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Drain planned events within a bounded window
    for (int w = 0; w < 400 && exp_q.size() > 0; w++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d planned events outstanding, expected 0", exp_q.size());
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
